// File: rtl/rc4_pkg.sv
// Shared arcfour constants and the message reader state encoding.
package rc4_pkg;

    localparam int MESSAGE_LENGTH     = 32;
    localparam int MESSAGE_LOG_LENGTH = 5;
    localparam int RAM_WIDTH          = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

endpackage

// File: rtl/message_reader_skid_fifo2.sv
// Two-entry FIFO with valid/ready on both sides.
// Latency: a word written in cycle n is visible at the head in cycle n+1.
// Backpressure: wr_rdy drops only when full and the head is not leaving this cycle.
module skid_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign rd_vld = (count != 2'd0);
    assign wr_rdy = (count != 2'd2) || rd_rdy;
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    // When full, a push lands in the slot being popped; the read sees the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/message_reader.sv
// Streams the winning core's A RAM (addresses 0..MESSAGE_LENGTH-1) as a valid/ready byte stream.
// Latency: first byte valid two clock edges after the edge that samples start; then 1 byte/cycle.
// Backpressure: reads are throttled by FIFO credit; out_data/out_last hold while stalled.
module message_reader #(
    parameter int NUM_CORES          = 2,
    parameter int LOG_NUM_CORES      = 8,
    parameter int MESSAGE_LENGTH     = rc4_pkg::MESSAGE_LENGTH,
    parameter int MESSAGE_LOG_LENGTH = rc4_pkg::MESSAGE_LOG_LENGTH,
    parameter int RAM_WIDTH          = rc4_pkg::RAM_WIDTH
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [LOG_NUM_CORES-1:0]        core_sel,
    output logic [MESSAGE_LOG_LENGTH-1:0]   rd_addr,
    input  logic [NUM_CORES*RAM_WIDTH-1:0]  rd_data,
    output logic [RAM_WIDTH-1:0]            out_data,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            sel_err
);

    import rc4_pkg::*;

    localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST_ADDR = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

    reader_state_t            state;
    reader_state_t            state_nxt;
    logic [LOG_NUM_CORES-1:0] sel_q;
    logic                     inflight;
    logic                     inflight_last;
    logic                     err_done;
    logic                     drain_done;
    logic                     sel_ok;
    logic                     issue;
    logic                     pop;
    logic [1:0]               fifo_count;
    logic [1:0]               credit_used;
    logic                     fifo_wr_rdy;
    logic [RAM_WIDTH-1:0]     ram_byte;

    assign sel_ok = int'(core_sel) < NUM_CORES;
    assign pop    = out_valid && out_ready;

    // A byte leaving this cycle frees its slot, so back-to-back reads sustain full rate.
    assign credit_used = fifo_count + {1'b0, inflight} - {1'b0, pop};
    assign issue       = (state == READ) && (credit_used < 2'd2);

    assign busy = (state != IDLE);
    assign done = drain_done || err_done;

    always_comb begin
        state_nxt  = state;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                if (start && sel_ok) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (issue && (rd_addr == LAST_ADDR)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid && !inflight) begin
                    state_nxt  = IDLE;
                    drain_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            sel_q         <= '0;
            rd_addr       <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            sel_err       <= 1'b0;
            err_done      <= 1'b0;
        end else begin
            state         <= state_nxt;
            err_done      <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && (rd_addr == LAST_ADDR);
            if ((state == IDLE) && start) begin
                if (sel_ok) begin
                    sel_q   <= core_sel;
                    rd_addr <= '0;
                    sel_err <= 1'b0;
                end else begin
                    sel_err  <= 1'b1;
                    err_done <= 1'b1;
                end
            end else if (issue && (rd_addr != LAST_ADDR)) begin
                rd_addr <= rd_addr + MESSAGE_LOG_LENGTH'(1);
            end
        end
    end

    // Only the latched selection steers the mux; core_sel is ignored mid-transfer.
    always_comb begin
        ram_byte = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (sel_q == LOG_NUM_CORES'(i)) begin
                ram_byte = rd_data[i*RAM_WIDTH +: RAM_WIDTH];
            end
        end
    end

    skid_fifo2 #(
        .WIDTH (RAM_WIDTH + 1)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .wr_vld (inflight),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat ({inflight_last, ram_byte}),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat ({out_last, out_data}),
        .count  (fifo_count)
    );

    no_overflow_a: assert property (@(posedge clk) disable iff (!reset) inflight |-> fifo_wr_rdy);

endmodule

// File: tb/tb_message_reader.sv
module tb_message_reader;

    localparam int NC  = 2;
    localparam int ML  = 32;
    localparam int MLL = 5;
    localparam int RW  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, start1;
    logic [7:0]        core_sel, core_sel1;
    logic              out_ready, out_ready1;
    logic [MLL-1:0]    rd_addr, rd_addr1;
    logic [NC*RW-1:0]  rd_data, rd_data1;
    logic [RW-1:0]     out_data, out_data1;
    logic              out_valid, out_valid1, out_last, out_last1;
    logic              busy, busy1, done, done1, sel_err, sel_err1;

    always #5 clk = ~clk;

    message_reader #(.NUM_CORES(NC), .LOG_NUM_CORES(8), .MESSAGE_LENGTH(ML),
                     .MESSAGE_LOG_LENGTH(MLL), .RAM_WIDTH(RW)) dut (
        .clk(clk), .reset(reset), .start(start), .core_sel(core_sel),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data),
        .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done), .sel_err(sel_err));

    message_reader #(.NUM_CORES(NC), .LOG_NUM_CORES(8), .MESSAGE_LENGTH(1),
                     .MESSAGE_LOG_LENGTH(MLL), .RAM_WIDTH(RW)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .core_sel(core_sel1),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .out_data(out_data1),
        .out_valid(out_valid1), .out_last(out_last1), .out_ready(out_ready1),
        .busy(busy1), .done(done1), .sel_err(sel_err1));

    // A RAM model: one-cycle read latency, shared address per reader
    logic [7:0] ram [NC][ML];
    always @(posedge clk) begin
        rd_data  <= {ram[1][rd_addr],  ram[0][rd_addr]};
        rd_data1 <= {ram[1][rd_addr1], ram[0][rd_addr1]};
    end

    int         n_chk = 0;
    int         n_fail = 0;
    int         acc_cnt = 0;
    int         done_cnt = 0;
    logic [8:0] exp_q [$];
    logic       stall_prev = 1'b0;
    logic [8:0] held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Expected stream: addresses 0..len-1 of the chosen core, last flag on the final one
    task automatic load_exp(input int sel, input int len);
        exp_q.delete();
        for (int a = 0; a < len; a++) exp_q.push_back({a == len - 1, ram[sel][a]});
    endtask

    // Scoreboard on the main reader
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_hold", {23'd0, out_last, out_data}, {23'd0, held});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_byte: actual %0h required none", {out_last, out_data});
                end else begin
                    check("stream_byte", {23'd0, out_last, out_data}, {23'd0, exp_q.pop_front()});
                end
                acc_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            held       = {out_last, out_data};
            if (done) done_cnt++;
        end
    end

    typedef struct {
        logic [7:0] sel;
        int         ready_pct;
        int         restart_at;
        bit         rand_data;
        int         exp_bytes;
        logic       exp_err;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input int idx, input vec_t v);
        int  cyc;
        bit  pulsed;
        if (v.rand_data)
            for (int c = 0; c < NC; c++)
                for (int a = 0; a < ML; a++) ram[c][a] = 8'($urandom);
        if (int'(v.sel) < NC) load_exp(int'(v.sel), ML);
        else exp_q.delete();
        acc_cnt  = 0;
        done_cnt = 0;
        pulsed   = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; core_sel = v.sel;
        out_ready = ($urandom_range(99) < v.ready_pct);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 400 && !(done_cnt > 0 && !busy)) begin
            out_ready = ($urandom_range(99) < v.ready_pct);
            if (v.restart_at >= 0 && !pulsed && acc_cnt >= v.restart_at) begin
                start = 1'b1; core_sel = 8'd0; pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("v%0d_no_timeout", idx), {31'd0, cyc < 400}, 32'd1);
        check($sformatf("v%0d_bytes", idx), acc_cnt, v.exp_bytes);
        check($sformatf("v%0d_exp_left", idx), exp_q.size(), 0);
        check($sformatf("v%0d_done_once", idx), done_cnt, 1);
        check($sformatf("v%0d_sel_err", idx), {31'd0, sel_err}, {31'd0, v.exp_err});
        check($sformatf("v%0d_idle", idx), {30'd0, busy, out_valid}, 32'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b0; start = 1'b0; core_sel = 8'd0; out_ready = 1'b0;
        start1 = 1'b0; core_sel1 = 8'd0; out_ready1 = 1'b0;
        for (int a = 0; a < ML; a++) begin
            ram[1][a] = 8'h61 + 8'(a);
            ram[0][a] = 8'($urandom);
        end
        vecs[0] = '{8'd1,   100, -1, 1'b0, 32, 1'b0};
        vecs[1] = '{8'd1,   50,  -1, 1'b0, 32, 1'b0};
        vecs[2] = '{8'd2,   100, -1, 1'b0, 0,  1'b1};
        vecs[3] = '{8'd0,   80,  -1, 1'b0, 32, 1'b0};
        vecs[4] = '{8'd1,   100, 5,  1'b0, 32, 1'b0};
        vecs[5] = '{8'hFF,  60,  -1, 1'b1, 0,  1'b1};
        vecs[6] = '{8'd0,   40,  12, 1'b1, 32, 1'b0};
        vecs[7] = '{8'd1,   25,  -1, 1'b1, 32, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_flags", {26'd0, out_valid, out_last, busy, done, sel_err, out_valid1}, 32'd0);
        reset = 1'b1;

        // Full-rate timing with core1 = 0x61..0x80
        load_exp(1, ML);
        acc_cnt = 0; done_cnt = 0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; core_sel = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_valid_e1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_valid_e2", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < ML; k++) begin
            @(negedge clk);
            check($sformatf("t1_valid_%0d", k), {31'd0, out_valid}, 32'd1);
            check($sformatf("t1_byte_%0d", k), {23'd0, out_last, out_data},
                  {23'd0, k == ML - 1, 8'h61 + 8'(k)});
        end
        @(negedge clk);
        check("t1_done", {30'd0, done, out_valid}, 32'd2);
        check("t1_addr_hold", {27'd0, rd_addr}, ML - 1);
        @(negedge clk);
        check("t1_after", {30'd0, done, busy}, 32'd0);
        check("t1_count", acc_cnt, ML);
        check("t1_done_cnt", done_cnt, 1);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset after 10 accepted bytes, then a fresh core0 transfer
        for (int a = 0; a < ML; a++) ram[1][a] = 8'h61 + 8'(a);
        load_exp(1, ML);
        acc_cnt = 0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; core_sel = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (acc_cnt < 10 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("t4_reached10", acc_cnt, 10);
        reset = 1'b0;
        #1;
        check("t4_rst_addr", {27'd0, rd_addr}, 32'd0);
        check("t4_rst_data", {24'd0, out_data}, 32'd0);
        check("t4_rst_flags", {27'd0, out_valid, out_last, busy, done, sel_err}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        run_vec(8, '{8'd0, 100, -1, 1'b0, 32, 1'b0});

        // Single-byte build: stall five cycles, then accept
        out_ready1 = 1'b0;
        @(posedge clk); #1;
        start1 = 1'b1; core_sel1 = 8'd1;
        @(posedge clk); #1;
        start1 = 1'b0;
        @(negedge clk);
        check("t6_valid_e1", {31'd0, out_valid1}, 32'd0);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t6_hold_%0d", k), {22'd0, out_valid1, out_last1, out_data1},
                  {22'd0, 1'b1, 1'b1, ram[1][0]});
            check($sformatf("t6_nodone_%0d", k), {31'd0, done1}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready1 = 1'b1;
        @(negedge clk);
        check("t6_accept", {22'd0, out_valid1, out_last1, out_data1}, {22'd0, 1'b1, 1'b1, ram[1][0]});
        @(negedge clk);
        check("t6_done", {30'd0, done1, out_valid1}, 32'd2);
        check("t6_addr", {27'd0, rd_addr1}, 32'd0);
        @(negedge clk);
        check("t6_after", {30'd0, done1, busy1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
